// File: rtl/add_subb_seq_pkg.sv
// add_subb_seq_pkg: shared widths and the signed-overflow check for the word-serial add/sub stage
package add_subb_seq_pkg;
    localparam int DEF_W = 8;
    localparam int DEF_N = 4;
    localparam int CW    = 2;

    function automatic int kw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // t = {x[W+1], x[W], x[W-1]} of the sign-extended MS-word sum
    function automatic logic ovf_of(input logic [2:0] t);
        return !(t[2] == t[1] && t[1] == t[0]);
    endfunction
endpackage

// File: rtl/add_subb_seq_if.sv
// add_subb_seq_if: operand stream in, result stream out, with per-frame negate flags
interface add_subb_seq_if #(parameter int W = 8);
    logic         subb_a;
    logic         subb_b;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         out_last;
    logic         c;
    logic         ovf;

    modport master (
        output subb_a, subb_b, in_valid, a, b, out_ready,
        input  in_ready, out_valid, s, out_last, c, ovf
    );
    modport slave (
        input  subb_a, subb_b, in_valid, a, b, out_ready,
        output in_ready, out_valid, s, out_last, c, ovf
    );
endinterface

// File: rtl/add_subb_cin.sv
// add_subb_cin: W-bit a+b+cin with 2-bit carry in/out and the sign-extended sum for overflow
import add_subb_seq_pkg::*;

module add_subb_cin #(
    parameter int W = DEF_W
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [CW-1:0] cin,
    output logic [W-1:0]  s,
    output logic [CW-1:0] cout,
    output logic [W+1:0]  x
);
    logic [W+1:0] sum;

    assign sum  = {2'b00, a} + {2'b00, b} + {{W{1'b0}}, cin};
    assign s    = sum[W-1:0];
    assign cout = sum[W+1:W];
    assign x    = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/add_subb_seq.sv
// add_subb_seq: word-serial multi-precision (+/-A)+(+/-B) with registered carry and 1-entry output
import add_subb_seq_pkg::*;

module add_subb_seq #(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic               clk,
    input  logic               rst,
    add_subb_seq_if.slave      bus
);
    localparam int KW = kw(N);

    logic [KW-1:0] k;
    logic [CW-1:0] carry;
    logic          sa_q, sb_q;
    logic          ov_q, last_q, c_q, ovf_q;
    logic [W-1:0]  s_q;

    logic          first, last, acc, sa, sb;
    logic [W-1:0]  an, bn, sum_s;
    logic [CW-1:0] cin, cout;
    logic [W+1:0]  x;

    assign first = (k == '0);
    assign last  = (k == KW'(N - 1));
    assign bus.in_ready = !ov_q || bus.out_ready;
    assign acc   = bus.in_valid && bus.in_ready;

    // On the first word the incoming negate flags apply directly and seed the carry-in
    always_comb begin
        sa  = first ? bus.subb_a : sa_q;
        sb  = first ? bus.subb_b : sb_q;
        an  = sa ? ~bus.a : bus.a;
        bn  = sb ? ~bus.b : bus.b;
        cin = first ? ({1'b0, bus.subb_a} + {1'b0, bus.subb_b}) : carry;
    end

    add_subb_cin #(.W(W)) u_cell (
        .a    (an),
        .b    (bn),
        .cin  (cin),
        .s    (sum_s),
        .cout (cout),
        .x    (x)
    );

    // Frame state and output register; a held output blocks acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            k      <= '0;
            carry  <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            ov_q   <= 1'b0;
            s_q    <= '0;
            last_q <= 1'b0;
            c_q    <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (acc) begin
            k      <= last ? '0 : k + KW'(1);
            carry  <= last ? '0 : cout;
            sa_q   <= sa;
            sb_q   <= sb;
            ov_q   <= 1'b1;
            s_q    <= sum_s;
            last_q <= last;
            c_q    <= last && cout[0];
            ovf_q  <= last && ovf_of(x[W+1:W-1]);
        end else if (bus.out_ready) begin
            ov_q   <= 1'b0;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.s         = s_q;
    assign bus.out_last  = last_q;
    assign bus.c         = c_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_add_subb_seq.sv
// tb_add_subb_seq: directed frames with hand-computed results, backpressure and mid-frame reset
module tb_add_subb_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    add_subb_seq_if #(.W(8)) bus ();

    add_subb_seq #(.W(8), .N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams one frame LS word first; flags are inverted after word 0 to prove they are latched
    task automatic run_frame(input string tag, input logic [31:0] av, input logic [31:0] bv,
                             input logic sa, input logic sb, input logic [31:0] exp,
                             input logic ec, input logic eo, input int stall_at);
        for (int i = 0; i < 4; i++) begin
            bus.a        = av[8*i +: 8];
            bus.b        = bv[8*i +: 8];
            bus.subb_a   = (i == 0) ? sa : !sa;
            bus.subb_b   = (i == 0) ? sb : !sb;
            bus.in_valid = 1'b1;
            tick();
            chk($sformatf("%s ov%0d", tag, i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("%s s%0d", tag, i), {24'd0, bus.s}, {24'd0, exp[8*i +: 8]});
            chk($sformatf("%s last%0d", tag, i), {31'd0, bus.out_last}, {31'd0, i == 3});
            if (i == 3) begin
                chk($sformatf("%s c", tag), {31'd0, bus.c}, {31'd0, ec});
                chk($sformatf("%s ovf", tag), {31'd0, bus.ovf}, {31'd0, eo});
            end
            if (i == stall_at) begin
                bus.out_ready = 1'b0;
                bus.a         = av[8*(i+1) +: 8];
                bus.b         = bv[8*(i+1) +: 8];
                bus.subb_a    = !sa;
                bus.subb_b    = !sb;
                #1;
                chk($sformatf("%s stall ir", tag), {31'd0, bus.in_ready}, 32'd0);
                for (int j = 0; j < 3; j++) begin
                    tick();
                    chk($sformatf("%s stall ov%0d", tag, j), {31'd0, bus.out_valid}, 32'd1);
                    chk($sformatf("%s stall s%0d", tag, j), {24'd0, bus.s}, {24'd0, exp[8*i +: 8]});
                    chk($sformatf("%s stall ir%0d", tag, j), {31'd0, bus.in_ready}, 32'd0);
                end
                bus.out_ready = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        tick();
        chk($sformatf("%s idle ov", tag), {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        bus.a         = '0;
        bus.b         = '0;
        bus.subb_a    = 1'b0;
        bus.subb_b    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        chk("rst ov", {31'd0, bus.out_valid}, 32'd0);
        chk("rst s", {24'd0, bus.s}, 32'd0);
        chk("rst last", {31'd0, bus.out_last}, 32'd0);
        chk("rst c", {31'd0, bus.c}, 32'd0);
        chk("rst ovf", {31'd0, bus.ovf}, 32'd0);
        rst = 1'b0;
        tick();

        run_frame("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, -1);
        run_frame("t2", 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0, -1);
        run_frame("t3", 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, -1);
        run_frame("t4", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, -1);
        run_frame("t5", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1);

        for (int i = 0; i < 2; i++) begin
            bus.a        = 8'hFF;
            bus.b        = 8'h01;
            bus.in_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        chk("t6 rst ov", {31'd0, bus.out_valid}, 32'd0);
        chk("t6 rst s", {24'd0, bus.s}, 32'd0);
        chk("t6 rst last", {31'd0, bus.out_last}, 32'd0);
        chk("t6 rst c", {31'd0, bus.c}, 32'd0);
        chk("t6 rst ovf", {31'd0, bus.ovf}, 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        run_frame("t6", 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0005, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
